bcd_2421_seq_ctrl: RTL and testbench
====================================

Name: bcd_2421_seq_ctrl

Overview:
Sequencing controller that converts a packed multi-digit 8421 BCD word to 2421 code. It uses one shared 4-bit 8421->2421 digit converter, one digit per clock, LSD first. It sits between a BCD producer and a 2421 consumer with valid/ready handshakes on both sides, and flags illegal digits (10-15) per position.

Parameters:
NDIGITS, 4, number of BCD digits per word (>=1); data width = 4*NDIGITS

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer has a word on bcd_in
in_ready  output  1  controller can accept a word
bcd_in  input  4*NDIGITS  packed 8421 digits, digit i = bits [4i+3:4i]
out_valid  output  1  converted word available
out_ready  input  1  consumer accepts the word
bcd_out  output  4*NDIGITS  packed 2421 digits, same positions as bcd_in
err_mask  output  NDIGITS  bit i set = input digit i was 10..15
err_any  output  1  OR of err_mask, valid with out_valid
busy  output  1  high in CONV or DONE

Behaviour:
- Digit map, 8421->2421: 0-4 -> 0000,0001,0010,0011,0100; 5->1011, 6->1100, 7->1101, 8->1110, 9->1111. Inputs 10-15 produce 0000 and set the err_mask bit.
- The map is computed by a single shared combinational converter, muxed by digit index. No per-digit converter replication.
- States are IDLE, CONV, DONE, with a digit index idx of width clog2(NDIGITS) (minimum 1).
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch bcd_in into the internal word register, set idx=0, clear bcd_out and err_mask, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge writes the converted digit idx into bcd_out[4idx+3:4idx] and its error bit into err_mask[idx], then idx++.
  - On the edge writing idx==NDIGITS-1, go to DONE.
- DONE:
  - out_valid=1.
  - bcd_out, err_mask and err_any are held stable while out_valid&&!out_ready (backpressure indefinite).
  - On out_ready, go to IDLE and drop out_valid next cycle.
- Latency: out_valid rises exactly NDIGITS edges after the accepting edge. Minimum word period is NDIGITS+2 cycles with out_ready tied high.
- in_ready is low in CONV and DONE. in_valid there is ignored, and the producer must hold its word.
- The internal word is latched at acceptance. Changes on bcd_in after acceptance do not affect the result.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.
- Reset values: state IDLE, idx 0, bcd_out 0, err_mask 0, err_any 0, out_valid 0, busy 0. in_ready reads 1 in the first cycle after rst deasserts.
- rst has priority over all handshakes.
- Reset mid-CONV or in DONE aborts: the partial or pending word is discarded, and no out_valid pulse follows.
- Edge case NDIGITS=1: CONV lasts one edge.

Test Plan:
- Reset, then N=4, bcd_in=16'h1937 with in_valid for one handshake -> out_valid exactly 4 edges later, bcd_out=16'h1F3D, err_mask=0000, err_any=0.
- Coverage sweep: words 16'h0123, 16'h4567, 16'h8998, out_ready high -> bcd_out 16'h0123, 16'h4BCD, 16'hEFFE. Consecutive in_ready rises are 6 cycles apart.
- Invalid digits: bcd_in=16'h5A0C -> bcd_out=16'hB000, err_mask=0101, err_any=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid are stable and in_ready=0 throughout. out_ready=1 -> IDLE next cycle with in_ready=1.
- Stability: change bcd_in and toggle in_valid during CONV -> result matches the latched word, and no second acceptance occurs.
- Reset mid-operation: assert rst for 1 cycle 2 edges into CONV -> out_valid never rises, bcd_out=0, in_ready=1 next cycle. A new word 16'h0009 then converts to 16'h000F.

Source files
------------

// File: rtl/bcd_2421_seq_ctrl.sv
// Sequencing controller: converts a packed multi-digit 8421 BCD word into
// 2421 code, one digit per clock (least significant digit first), through a
// single shared digit converter. Illegal input digits (10..15) are converted
// to 0000 and flagged per position in err_mask.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds bcd_in/in_valid until in_ready is seen; the
// controller holds bcd_out/err_mask/err_any/out_valid until out_ready is
// seen. in_ready and out_valid are decoded from state only, so neither
// depends combinationally on in_valid or out_ready.
module bcd_2421_seq_ctrl #(
  parameter int NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   bcd_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NDIGITS-1:0]   bcd_out,
  output logic [NDIGITS-1:0]     err_mask,
  output logic                   err_any,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [IW-1:0]        r_idx;
  logic [4*NDIGITS-1:0] r_word;
  logic [4*NDIGITS-1:0] r_bcd_out;
  logic [NDIGITS-1:0]   r_err_mask;

  logic [3:0]           w_digit;
  logic [3:0]           w_conv;
  logic                 w_err;

  // Select the digit currently being converted from the latched word.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (r_idx == IW'(i)) w_digit = r_word[4*i +: 4];
    end
  end

  // Shared 8421 -> 2421 digit converter; 10..15 map to 0000 with error.
  always_comb begin
    w_conv = 4'b0000;
    w_err  = 1'b0;
    case (w_digit)
      4'd0: w_conv = 4'b0000;
      4'd1: w_conv = 4'b0001;
      4'd2: w_conv = 4'b0010;
      4'd3: w_conv = 4'b0011;
      4'd4: w_conv = 4'b0100;
      4'd5: w_conv = 4'b1011;
      4'd6: w_conv = 4'b1100;
      4'd7: w_conv = 4'b1101;
      4'd8: w_conv = 4'b1110;
      4'd9: w_conv = 4'b1111;
      default: w_err = 1'b1;
    endcase
  end

  // Control FSM plus word/result registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_word     <= '0;
      r_bcd_out  <= '0;
      r_err_mask <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_word     <= bcd_in;
            r_idx      <= '0;
            r_bcd_out  <= '0;
            r_err_mask <= '0;
            r_state    <= S_CONV;
          end
        end
        S_CONV: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (r_idx == IW'(i)) begin
              r_bcd_out[4*i +: 4] <= w_conv;
              r_err_mask[i]       <= w_err;
            end
          end
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_CONV) || (r_state == S_DONE);
  assign bcd_out   = r_bcd_out;
  assign err_mask  = r_err_mask;
  assign err_any   = |r_err_mask;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_2421_seq_ctrl.sv
// Bench for bcd_2421_seq_ctrl: directed scenarios plus randomized words and
// randomized consumer backpressure. Expected results come from a digit-wise
// arithmetic model and flow through a queue to an independent monitor.
module tb_bcd_2421_seq_ctrl;

  localparam int N  = 4;
  localparam int W  = 4 * N;
  localparam int EW = W + N;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  bcd_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  bcd_out;
  logic [N-1:0]  err_mask;
  logic          err_any;
  logic          busy;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_done = 0;

  logic [EW-1:0] exp_q[$];
  int            acc_q[$];
  int            rise_q[$];

  bcd_2421_seq_ctrl #(.NDIGITS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .bcd_in(bcd_in),
    .out_valid(out_valid), .out_ready(out_ready), .bcd_out(bcd_out),
    .err_mask(err_mask), .err_any(err_any), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // 0..4 pass through, 5..9 gain 6, 10..15 become 0 and raise the flag.
  function automatic logic [EW-1:0] model(input logic [W-1:0] word);
    logic [W-1:0] o;
    logic [N-1:0] m;
    int d;
    o = '0;
    m = '0;
    for (int i = 0; i < N; i++) begin
      d = int'((word >> (4 * i)) & 16'hF);
      if (d < 5)       o = o | (W'(d) << (4 * i));
      else if (d < 10) o = o | (W'(d + 6) << (4 * i));
      else             m[i] = 1'b1;
    end
    return {o, m};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Present one word, complete the handshake, and record expectation.
  task automatic send_word(input logic [W-1:0] w, input bit noisy);
    wait_in_ready();
    in_valid = 1'b1;
    bcd_in   = w;
    @(posedge clk); #1;
    exp_q.push_back(model(w));
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    if (noisy) begin
      for (int i = 0; i < N - 1; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        bcd_in   = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w = '0;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 3) == 0) w = w | (W'($urandom_range(10, 15)) << (4 * i));
      else                           w = w | (W'($urandom_range(0, 9)) << (4 * i));
    end
    return w;
  endfunction

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic          prev_valid = 1'b0;
    logic          prev_hold  = 1'b0;
    logic          prev_ready = 1'b0;
    logic [W+N:0]  snap       = '0;
    logic [EW-1:0] e;
    int            a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_ready && !prev_ready) rise_q.push_back(cyc);
        if (out_valid && !prev_valid) begin
          if (acc_q.size() != 0) begin
            a = acc_q.pop_front();
            check("latency", 32'(cyc - a), 32'(N));
          end else begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
          end
        end
        if (prev_hold)
          check("hold_stable", 32'({out_valid, bcd_out, err_mask, err_any}),
                32'({1'b1, snap}));
        if (out_valid && out_ready) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("bcd_out", 32'(bcd_out), 32'(e[EW-1:N]));
            check("err_mask", 32'(err_mask), 32'(e[N-1:0]));
            check("err_any", 32'(err_any), 32'(|e[N-1:0]));
          end else begin
            check("unexpected_output", 32'(out_valid), 32'd0);
          end
        end
      end
      prev_valid = out_valid && !rst;
      prev_hold  = out_valid && !out_ready && !rst;
      prev_ready = in_ready;
      snap       = {bcd_out, err_mask, err_any};
    end
  end

  // ---------------- main stimulus ----------------
  initial begin : main
    logic [W+N:0] hold_snap;
    int n;
    rst = 1'b1; in_valid = 1'b0; bcd_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd_out", 32'(bcd_out), 32'd0);
    check("rst_err_mask", 32'(err_mask), 32'd0);
    check("rst_err_any", 32'(err_any), 32'd0);
    @(posedge clk); #1;

    // basic word
    send_word(16'h1937, 1'b0);
    wait_drain();

    // back-to-back sweep with consumer always ready
    rise_q.delete();
    send_word(16'h0123, 1'b0);
    send_word(16'h4567, 1'b0);
    send_word(16'h8998, 1'b0);
    wait_drain();
    check("rise_count", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() >= 3) begin
      check("in_ready_period_1", 32'(rise_q[1] - rise_q[0]), 32'(N + 2));
      check("in_ready_period_2", 32'(rise_q[2] - rise_q[1]), 32'(N + 2));
    end

    // illegal digits
    send_word(16'h5A0C, 1'b0);
    wait_drain();

    // backpressure
    out_ready = 1'b0;
    send_word(rand_word(), 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid_seen", 32'(out_valid), 32'd1);
    hold_snap = {bcd_out, err_mask, err_any};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_outputs", 32'({bcd_out, err_mask, err_any}), 32'(hold_snap));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    wait_drain();

    // input noise while converting
    send_word(16'h2468, 1'b1);
    wait_drain();
    send_word(rand_word(), 1'b1);
    wait_drain();

    // reset two edges into conversion
    send_word(16'h9876, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_bcd_out", 32'(bcd_out), 32'd0);
    check("abort_err_mask", 32'(err_mask), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    send_word(16'h0009, 1'b0);
    wait_drain();

    // randomized words with random consumer backpressure
    fork
      begin
        for (int k = 0; k < 40; k++) send_word(rand_word(), 1'($urandom_range(0, 1)));
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
